// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Multi-cycle instruction sequencer for a small accumulator machine. Each
// instruction is fetched from a byte-wide program memory, decoded, optionally
// followed by one immediate operand byte, and executed in a single cycle. The
// unit drives the ALU select, register file and accumulator controls. Jumps
// and the sticky HALT state are handled here as well.
//
// Instruction format: opcode = IR[7:4], register / rotate field = IR[2:0].
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   rst         synchronous active-high reset, dominates everything
//   enable      1 = sequencer advances; 0 = all registers hold and the
//               write enables are forced low
//   mem_data    program byte at pc_out (combinational read, same cycle)
//   acc_zero    accumulator == 8'h00, sampled by JZ in EXECUTE
//   pc_out      program counter / program memory address
//   alu_sel     ALU operation select
//   num_rotate  rotate amount for ROR
//   rf_addr     register file address
//   rf_we       register file write enable (write data is the accumulator)
//   acc_we      accumulator load enable
//   acc_src     0 = accumulator loads ALU result, 1 = loads imm_out
//   imm_out     latched immediate operand byte
//   halted      high while in HALT
//   state_out   current state encoding, for debug
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [7:0]          mem_data,
  input  logic                acc_zero,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [3:0]          alu_sel,
  output logic [1:0]          num_rotate,
  output logic [2:0]          rf_addr,
  output logic                rf_we,
  output logic                acc_we,
  output logic                acc_src,
  output logic [7:0]          imm_out,
  output logic                halted,
  output logic [2:0]          state_out
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_AND  = 4'b0001,
    OP_OR   = 4'b0010,
    OP_ADD  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_INC  = 4'b0101,
    OP_DEC  = 4'b0110,
    OP_ROR  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_LDA  = 4'b1001,
    OP_STA  = 4'b1010,
    OP_LDI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_JZ   = 4'b1101,
    OP_UND  = 4'b1110,
    OP_HALT = 4'b1111
  } opcode_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic [7:0]          imm_q, imm_d;

  opcode_t             opcode;
  logic                is_alu_op;
  logic [PC_WIDTH-1:0] jump_target;

  assign opcode = opcode_t'(ir_q[7:4]);

  // AND .. LDA all share the same control pattern: alu_sel follows the opcode
  // and the accumulator captures the ALU result.
  assign is_alu_op = opcode inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_INC,
                                    OP_DEC, OP_ROR, OP_SLT, OP_LDA};

  // The immediate is always a byte; narrow program counters take its low
  // bits, wide ones zero-extend it.
  generate
    if (PC_WIDTH <= 8) begin : g_jump_narrow
      assign jump_target = imm_q[PC_WIDTH-1:0];
    end else begin : g_jump_wide
      assign jump_target = {{(PC_WIDTH-8){1'b0}}, imm_q};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic. With enable low every register keeps its value, which
  // freezes an instruction exactly where it is and lets it resume later.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;

    if (enable) begin
      case (state_q)
        S_FETCH: begin
          ir_d    = mem_data;
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = S_DECODE;
        end

        S_DECODE: begin
          case (opcode)
            OP_LDI, OP_JMP, OP_JZ: state_d = S_OPERAND;
            OP_HALT:               state_d = S_HALT;
            default:               state_d = S_EXECUTE;
          endcase
        end

        S_OPERAND: begin
          imm_d   = mem_data;
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = S_EXECUTE;
        end

        S_EXECUTE: begin
          // A not-taken JZ simply falls through: pc already points past the
          // operand byte.
          if (opcode == OP_JMP || (opcode == OP_JZ && acc_zero)) begin
            pc_d = jump_target;
          end
          state_d = S_FETCH;
        end

        // Sticky until reset; pc is held by the defaults.
        S_HALT: state_d = S_HALT;

        // Unused encodings recover to FETCH on the next cycle.
        default: state_d = S_FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers (synchronous reset, reset has priority over enable)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Datapath selects follow IR while an instruction is in
  // flight (DECODE, OPERAND, EXECUTE) so the datapath settles early; write
  // enables pulse only in EXECUTE and only while enable is high. States
  // 5-7 fall through to the zero defaults.
  // ---------------------------------------------------------------------------
  logic in_flight;
  logic in_execute;

  assign in_flight  = (state_q == S_DECODE) || (state_q == S_OPERAND) ||
                      (state_q == S_EXECUTE);
  assign in_execute = (state_q == S_EXECUTE);

  always_comb begin
    alu_sel    = 4'b0000;
    num_rotate = 2'd0;
    rf_addr    = 3'd0;
    rf_we      = 1'b0;
    acc_we     = 1'b0;
    acc_src    = 1'b0;

    if (in_flight) begin
      if (is_alu_op) begin
        alu_sel = ir_q[7:4];
        rf_addr = ir_q[2:0];
      end else if (opcode == OP_STA) begin
        rf_addr = ir_q[2:0];
      end else if (opcode == OP_LDI) begin
        acc_src = 1'b1;
      end
    end

    if (in_execute) begin
      if (opcode == OP_ROR) begin
        num_rotate = ir_q[1:0];
      end
      if (enable) begin
        acc_we = is_alu_op || (opcode == OP_LDI);
        rf_we  = (opcode == OP_STA);
      end
    end
  end

  assign pc_out    = pc_q;
  assign imm_out   = imm_q;
  assign halted    = (state_q == S_HALT);
  assign state_out = state_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Directed bench for control_unit. A 256-byte program memory is read
// combinationally at pc_out. Every test reloads memory, resets the unit and
// then walks it cycle by cycle; outputs are sampled 1 ns after the rising
// edge, which is also when the inputs are driven. Expected values are
// hand-derived from the instruction timing (FETCH, DECODE, [OPERAND],
// EXECUTE).
// -----------------------------------------------------------------------------
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] mem_data;
  logic       acc_zero;
  logic [7:0] pc_out;
  logic [3:0] alu_sel;
  logic [1:0] num_rotate;
  logic [2:0] rf_addr;
  logic       rf_we;
  logic       acc_we;
  logic       acc_src;
  logic [7:0] imm_out;
  logic       halted;
  logic [2:0] state_out;

  logic [7:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  control_unit #(.PC_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mem_data   (mem_data),
    .acc_zero   (acc_zero),
    .pc_out     (pc_out),
    .alu_sel    (alu_sel),
    .num_rotate (num_rotate),
    .rf_addr    (rf_addr),
    .rf_we      (rf_we),
    .acc_we     (acc_we),
    .acc_src    (acc_src),
    .imm_out    (imm_out),
    .halted     (halted),
    .state_out  (state_out)
  );

  assign mem_data = mem[pc_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // After this returns the unit is in cycle 1 (FETCH at pc 0).
  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_mem();
    mem[0] = 8'hB0;
    mem[1] = 8'h77;
    acc_zero = 1'b0;
    do_reset();
    step();
    step();
    // Reset in the middle of an LDI (OPERAND state).
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (state_out !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", state_out);
    end
    checks++;
    if (pc_out !== 8'h00) begin
      errors++; $display("FAIL reset_pc: got %0h want 00", pc_out);
    end
    checks++;
    if ({alu_sel, num_rotate, rf_addr, rf_we, acc_we, acc_src, halted} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got alu=%0h rot=%0d rf=%0d rfwe=%0b accwe=%0b src=%0b halt=%0b want all 0",
               alu_sel, num_rotate, rf_addr, rf_we, acc_we, acc_src, halted);
    end
    checks++;
    if (imm_out !== 8'h00) begin
      errors++; $display("FAIL reset_imm: got %0h want 00", imm_out);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_add_halt();
    logic [2:0] exp_st [7];
    exp_st = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd4, 3'd4};
    clear_mem();
    mem[0] = 8'h31;
    mem[1] = 8'hF0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (state_out !== exp_st[c]) begin
        errors++; $display("FAIL add_state c%0d: got %0d want %0d", c + 1, state_out, exp_st[c]);
      end
      checks++;
      if (halted !== (exp_st[c] == 3'd4)) begin
        errors++; $display("FAIL add_halted c%0d: got %0b want %0b", c + 1, halted, exp_st[c] == 3'd4);
      end
      checks++;
      if (acc_we !== (c == 2)) begin
        errors++; $display("FAIL add_acc_we c%0d: got %0b want %0b", c + 1, acc_we, c == 2);
      end
      if (c == 2) begin
        checks++;
        if (alu_sel !== 4'b0011 || rf_addr !== 3'd1 || acc_src !== 1'b0) begin
          errors++;
          $display("FAIL add_exec: got alu=%0h rf=%0d src=%0b want alu=3 rf=1 src=0", alu_sel, rf_addr, acc_src);
        end
      end
      step();
    end
    checks++;
    if (pc_out !== 8'h02 || halted !== 1'b1 || alu_sel !== 4'b0000) begin
      errors++; $display("FAIL halt_hold: got pc=%0h halted=%0b alu=%0h want pc=02 halted=1 alu=0", pc_out, halted, alu_sel);
    end
    // Only reset leaves HALT.
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (state_out !== 3'd0 || halted !== 1'b0 || pc_out !== 8'h00) begin
      errors++; $display("FAIL halt_reset: got st=%0d halted=%0b pc=%0h want st=0 halted=0 pc=00", state_out, halted, pc_out);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ldi();
    clear_mem();
    mem[0] = 8'hB0;
    mem[1] = 8'h5A;
    do_reset();
    step();
    step();
    checks++;
    if (state_out !== 3'd2 || acc_we !== 1'b0 || acc_src !== 1'b1) begin
      errors++; $display("FAIL ldi_operand: got st=%0d accwe=%0b src=%0b want st=2 accwe=0 src=1", state_out, acc_we, acc_src);
    end
    step();
    checks++;
    if (state_out !== 3'd3 || acc_we !== 1'b1 || acc_src !== 1'b1 || imm_out !== 8'h5A) begin
      errors++;
      $display("FAIL ldi_exec: got st=%0d accwe=%0b src=%0b imm=%0h want st=3 accwe=1 src=1 imm=5a",
               state_out, acc_we, acc_src, imm_out);
    end
    step();
    checks++;
    if (state_out !== 3'd0 || pc_out !== 8'h02 || acc_we !== 1'b0) begin
      errors++; $display("FAIL ldi_after: got st=%0d pc=%0h accwe=%0b want st=0 pc=02 accwe=0", state_out, pc_out, acc_we);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_jz();
    logic [7:0] exp_pc [2];
    exp_pc = '{8'h10, 8'h02};
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      mem[0] = 8'hD0;
      mem[1] = 8'h10;
      acc_zero = (k == 0);
      do_reset();
      step();
      step();
      step();
      checks++;
      if (state_out !== 3'd3 || acc_we !== 1'b0 || rf_we !== 1'b0) begin
        errors++; $display("FAIL jz_exec k%0d: got st=%0d accwe=%0b rfwe=%0b want st=3 0 0", k, state_out, acc_we, rf_we);
      end
      step();
      checks++;
      if (pc_out !== exp_pc[k] || state_out !== 3'd0) begin
        errors++; $display("FAIL jz_pc k%0d: got pc=%0h st=%0d want pc=%0h st=0", k, pc_out, state_out, exp_pc[k]);
      end
    end
    acc_zero = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ror();
    clear_mem();
    mem[0] = 8'h73;
    do_reset();
    step();
    checks++;
    if (num_rotate !== 2'd0 || alu_sel !== 4'b0111) begin
      errors++; $display("FAIL ror_decode: got rot=%0d alu=%0h want rot=0 alu=7", num_rotate, alu_sel);
    end
    step();
    checks++;
    if (state_out !== 3'd3 || alu_sel !== 4'b0111 || num_rotate !== 2'd3 || acc_we !== 1'b1 || rf_addr !== 3'd3) begin
      errors++;
      $display("FAIL ror_exec: got st=%0d alu=%0h rot=%0d accwe=%0b rf=%0d want st=3 alu=7 rot=3 accwe=1 rf=3",
               state_out, alu_sel, num_rotate, acc_we, rf_addr);
    end
    step();
    checks++;
    if (state_out !== 3'd0 || num_rotate !== 2'd0 || alu_sel !== 4'b0000) begin
      errors++; $display("FAIL ror_fetch: got st=%0d rot=%0d alu=%0h want st=0 rot=0 alu=0", state_out, num_rotate, alu_sel);
    end
  endtask

  // ---------------------------------------------------------------------------
  // NOP, undefined 1110 and LDA back to back.
  task automatic test_nop_undef_lda();
    clear_mem();
    mem[0] = 8'h00;
    mem[1] = 8'hE7;
    mem[2] = 8'h96;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      step();
      step();
      checks++;
      if (state_out !== 3'd3 || {alu_sel, rf_addr, rf_we, acc_we, acc_src} !== 10'd0) begin
        errors++;
        $display("FAIL nop_exec n%0d: got st=%0d alu=%0h rf=%0d rfwe=%0b accwe=%0b src=%0b want st=3 all 0",
                 n, state_out, alu_sel, rf_addr, rf_we, acc_we, acc_src);
      end
      step();
    end
    step();
    step();
    checks++;
    if (state_out !== 3'd3 || alu_sel !== 4'b1001 || rf_addr !== 3'd6 || acc_we !== 1'b1 || acc_src !== 1'b0) begin
      errors++;
      $display("FAIL lda_exec: got st=%0d alu=%0h rf=%0d accwe=%0b src=%0b want st=3 alu=9 rf=6 accwe=1 src=0",
               state_out, alu_sel, rf_addr, acc_we, acc_src);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_enable_stall();
    int pulses;
    clear_mem();
    mem[0] = 8'hB0;
    mem[1] = 8'h5A;
    do_reset();
    step();
    step();
    // OPERAND, pc = 1. Freeze for three edges.
    enable = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      checks++;
      if (state_out !== 3'd2 || pc_out !== 8'h01 || acc_we !== 1'b0 || imm_out !== 8'h00) begin
        errors++;
        $display("FAIL stall_operand s%0d: got st=%0d pc=%0h accwe=%0b imm=%0h want st=2 pc=01 accwe=0 imm=00",
                 s, state_out, pc_out, acc_we, imm_out);
      end
    end
    enable = 1'b1;
    pulses = 0;
    step();
    checks++;
    if (state_out !== 3'd3 || pc_out !== 8'h02 || imm_out !== 8'h5A) begin
      errors++; $display("FAIL stall_resume: got st=%0d pc=%0h imm=%0h want st=3 pc=02 imm=5a", state_out, pc_out, imm_out);
    end
    // Stall inside EXECUTE too: the write enable must drop while frozen.
    enable = 1'b0;
    #1;
    checks++;
    if (acc_we !== 1'b0) begin
      errors++; $display("FAIL stall_exec_we: got %0b want 0", acc_we);
    end
    step();
    checks++;
    if (state_out !== 3'd3 || acc_we !== 1'b0) begin
      errors++; $display("FAIL stall_exec_hold: got st=%0d accwe=%0b want st=3 accwe=0", state_out, acc_we);
    end
    enable = 1'b1;
    #1;
    for (int s = 0; s < 4; s++) begin
      if (acc_we === 1'b1) pulses++;
      step();
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL stall_pulses: got %0d want 1", pulses);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sta_reset();
    clear_mem();
    mem[0] = 8'h00;
    mem[1] = 8'hA5;
    do_reset();
    repeat (5) step();
    checks++;
    if (state_out !== 3'd3 || rf_we !== 1'b1 || rf_addr !== 3'd5 || alu_sel !== 4'b0000 || acc_we !== 1'b0) begin
      errors++;
      $display("FAIL sta_exec: got st=%0d rfwe=%0b rf=%0d alu=%0h accwe=%0b want st=3 rfwe=1 rf=5 alu=0 accwe=0",
               state_out, rf_we, rf_addr, alu_sel, acc_we);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (state_out !== 3'd0 || pc_out !== 8'h00 || rf_we !== 1'b0 || rf_addr !== 3'd0) begin
      errors++;
      $display("FAIL sta_reset: got st=%0d pc=%0h rfwe=%0b rf=%0d want st=0 pc=00 rfwe=0 rf=0", state_out, pc_out, rf_we, rf_addr);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Operand bytes sitting across the top of the address space.
  task automatic test_wrap();
    clear_mem();
    mem[8'h00] = 8'hC0;
    mem[8'h01] = 8'hFE;
    mem[8'hFE] = 8'hC0;
    mem[8'hFF] = 8'h00;
    do_reset();
    repeat (4) step();
    checks++;
    if (state_out !== 3'd0 || pc_out !== 8'hFE) begin
      errors++; $display("FAIL wrap_jmp_fe: got st=%0d pc=%0h want st=0 pc=fe", state_out, pc_out);
    end
    step();
    step();
    checks++;
    if (state_out !== 3'd2 || pc_out !== 8'hFF) begin
      errors++; $display("FAIL wrap_operand: got st=%0d pc=%0h want st=2 pc=ff", state_out, pc_out);
    end
    step();
    checks++;
    if (state_out !== 3'd3 || pc_out !== 8'h00 || imm_out !== 8'h00) begin
      errors++; $display("FAIL wrap_exec: got st=%0d pc=%0h imm=%0h want st=3 pc=00 imm=00", state_out, pc_out, imm_out);
    end
    step();
    checks++;
    if (state_out !== 3'd0 || pc_out !== 8'h00) begin
      errors++; $display("FAIL wrap_after: got st=%0d pc=%0h want st=0 pc=00", state_out, pc_out);
    end

    // LDI at 0xFF: its operand comes from address 0 after the wrap.
    clear_mem();
    mem[8'h00] = 8'hC0;
    mem[8'h01] = 8'hFF;
    mem[8'hFF] = 8'hB0;
    do_reset();
    repeat (5) step();
    checks++;
    if (state_out !== 3'd1 || pc_out !== 8'h00) begin
      errors++; $display("FAIL wrap_ldi_decode: got st=%0d pc=%0h want st=1 pc=00", state_out, pc_out);
    end
    step();
    step();
    checks++;
    if (state_out !== 3'd3 || imm_out !== 8'hC0 || acc_we !== 1'b1 || acc_src !== 1'b1 || pc_out !== 8'h01) begin
      errors++;
      $display("FAIL wrap_ldi_exec: got st=%0d imm=%0h accwe=%0b src=%0b pc=%0h want st=3 imm=c0 accwe=1 src=1 pc=01",
               state_out, imm_out, acc_we, acc_src, pc_out);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst      = 1'b1;
    enable   = 1'b1;
    acc_zero = 1'b0;
    clear_mem();
    #2;
    test_reset();
    test_add_halt();
    test_ldi();
    test_jz();
    test_ror();
    test_nop_undef_lda();
    test_enable_stall();
    test_sta_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
